// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader.
//   - loader FSM state encoding
//   - word width, index width and header count width shared with the
//     instruction memory
//   - header byte count and a small byte-count helper
// Optional feature macro used by the loader: IMEM_LOADER_CHKSUM_EN
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    // Widths agreed with the instruction memory and the image format
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_CNT_W  = 16;

    // Number of whole bytes in a field of the given bit width
    function automatic int byteCount(input int width);
        return width / 8;
    endfunction

    // Larger of two widths; sizes the shared byte packer
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bytes in the little-endian word-count header
    localparam int IMEM_HDR_BYTES = byteCount(IMEM_CNT_W);

    // Loader states; CHK is only reachable when the checksum option is built in
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5,
        ST_CHK   = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
// Little-endian shift-in assembly of up to W/8 bytes. The first byte of a
// word lands in [7:0]. The number of bytes that complete a word is chosen per
// use through i_nbytes, so the same packer serves the header and data words.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   i_clear      restart assembly (byte counter and word to zero)
//   i_load       a byte is accepted this cycle
//   i_byte       the accepted byte
//   i_nbytes     bytes that make up the current word
//   o_wordNext   word including the byte being accepted this cycle
//   o_wordFull   the byte accepted this cycle completes the word
// ---------------------------------------------------------------------------
module imem_loader_byte_packer #(
    parameter int W  = 32,
    parameter int CW = $clog2(W / 8 + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [7:0]    i_byte,
    input  logic [CW-1:0] i_nbytes,
    output logic [W-1:0]  o_wordNext,
    output logic          o_wordFull
);

    localparam int NB = W / 8;

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_word;

    // Merge the incoming byte into the lane selected by the byte counter.
    // The merged value is exposed so the caller can capture a completed word
    // on the same edge that accepts its final byte.
    always_comb begin
        o_wordNext = r_word;
        for (int b = 0; b < NB; b++) begin
            if (CW'(b) == r_cnt) begin
                o_wordNext[b*8 +: 8] = i_byte;
            end
        end
        o_wordFull = i_load && (r_cnt == (i_nbytes - 1'b1));
    end

    // Byte counter restarts after every completed word; partial words are
    // kept across input gaps because nothing changes without i_load.
    always_ff @(posedge clk_i) begin
        if (rst_i || i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_word <= o_wordNext;
            r_cnt  <= o_wordFull ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader in front of the instruction memory write port.
// Receives a little-endian byte stream: a CNT_W-bit word count N followed by
// N DATA_W-bit words. Words are written to indices 0..N-1 and the core is
// held in reset until the whole image has landed.
//
// Optional feature macro: IMEM_LOADER_CHKSUM_EN
//   When defined, one trailing byte holding the modulo-256 sum of all data
//   bytes is checked after the last word; mismatch aborts the load.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       one-cycle pulse; starts a load from IDLE, DONE or ERR
//   byte_i        stream byte
//   byte_valid_i  stream byte valid
//   byte_ready_o  loader accepts a byte this cycle (state-only)
//   WE_o          instruction-memory write enable
//   AddrW_o       instruction-memory write index
//   DataW_o       instruction-memory write data
//   cpu_rst_o     core reset, released only in DONE
//   busy_o        load in progress
//   done_o        image loaded successfully
//   err_o         load aborted
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int CNT_W  = IMEM_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              WE_o,
    output logic [ADDR_W-1:0] AddrW_o,
    output logic [DATA_W-1:0] DataW_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int          HDR_BYTES  = (CNT_W == IMEM_CNT_W) ? IMEM_HDR_BYTES : byteCount(CNT_W);
    localparam int          WORD_BYTES = byteCount(DATA_W);
    localparam int          PACK_W     = maxInt(DATA_W, CNT_W);
    localparam int          PCW        = $clog2(PACK_W / 8 + 1);
    localparam logic [63:0] DEPTH      = 64'd1 << ADDR_W;

    state_t r_state;
    state_t w_nextState;

    logic              r_we;
    logic [ADDR_W-1:0] r_addrW;
    logic [DATA_W-1:0] r_dataW;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_wordsDone;
    logic [ADDR_W-1:0] r_index;

    logic              w_accept;
    logic              w_startOk;
    logic              w_packLoad;
    logic [PCW-1:0]    w_nbytes;
    logic [PACK_W-1:0] w_packNext;
    logic              w_packFull;
    logic [CNT_W-1:0]  w_hdrN;
    logic              w_nTooBig;
    logic [CNT_W-1:0]  w_wordsNext;

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0] r_sum;
`endif

    // Handshake and packer control. Only HDR and DATA feed the packer, so
    // bytes drained in ERR never disturb assembly state.
    always_comb begin
        w_accept    = byte_valid_i && byte_ready_o;
        w_startOk   = start_i && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
        w_packLoad  = w_accept && (r_state == ST_HDR || r_state == ST_DATA);
        w_nbytes    = (r_state == ST_HDR) ? PCW'(HDR_BYTES) : PCW'(WORD_BYTES);
        w_hdrN      = w_packNext[CNT_W-1:0];
        w_nTooBig   = 64'(w_hdrN) > DEPTH;
        w_wordsNext = r_wordsDone + 1'b1;
    end

    imem_loader_byte_packer #(
        .W  (PACK_W),
        .CW (PCW)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_clear    (w_startOk),
        .i_load     (w_packLoad),
        .i_byte     (byte_i),
        .i_nbytes   (w_nbytes),
        .o_wordNext (w_packNext),
        .o_wordFull (w_packFull)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. An empty image still passes through CHK when the
    // checksum option is built in, expecting a sum of zero.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_nextState = ST_HDR;
            end
            ST_HDR: begin
                if (w_packFull) begin
                    if (w_hdrN == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        w_nextState = ST_CHK;
`else
                        w_nextState = ST_DONE;
`endif
                    end else if (w_nTooBig) begin
                        w_nextState = ST_ERR;
                    end else begin
                        w_nextState = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_packFull) w_nextState = ST_WRITE;
            end
            ST_WRITE: begin
                if (w_wordsNext == r_count) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                    w_nextState = ST_CHK;
`else
                    w_nextState = ST_DONE;
`endif
                end else begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DONE: begin
                if (start_i) w_nextState = ST_HDR;
            end
            ST_ERR: begin
                if (start_i) w_nextState = ST_HDR;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (w_accept) w_nextState = (byte_i == r_sum) ? ST_DONE : ST_ERR;
            end
`endif
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Status outputs are decoded purely from state so byte_ready_o never
    // depends on byte_valid_i.
    always_comb begin
        byte_ready_o = (r_state == ST_HDR) || (r_state == ST_DATA) ||
                       (r_state == ST_ERR) || (r_state == ST_CHK);
        busy_o       = (r_state == ST_HDR) || (r_state == ST_DATA) ||
                       (r_state == ST_WRITE) || (r_state == ST_CHK);
        done_o       = (r_state == ST_DONE);
        err_o        = (r_state == ST_ERR);
        cpu_rst_o    = (r_state != ST_DONE);
    end

    // Write port registers are loaded on the edge that accepts the final byte
    // of a word, so they are valid exactly while the FSM sits in WRITE and
    // hold their values afterwards. The index simply wraps at ADDR_W bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we        <= 1'b0;
            r_addrW     <= '0;
            r_dataW     <= '0;
            r_count     <= '0;
            r_wordsDone <= '0;
            r_index     <= '0;
        end else begin
            r_we <= (r_state == ST_DATA) && w_packFull;
            if ((r_state == ST_DATA) && w_packFull) begin
                r_addrW <= r_index;
                r_dataW <= w_packNext[DATA_W-1:0];
            end
            if (w_startOk) begin
                r_count     <= '0;
                r_wordsDone <= '0;
                r_index     <= '0;
            end else if ((r_state == ST_HDR) && w_packFull) begin
                r_count <= w_hdrN;
            end else if (r_state == ST_WRITE) begin
                r_index     <= r_index + 1'b1;
                r_wordsDone <= w_wordsNext;
            end
        end
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    // Running modulo-256 sum of data bytes only; header bytes are excluded.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_startOk) begin
            r_sum <= '0;
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_sum <= r_sum + byte_i;
        end
    end
`endif

    assign WE_o    = r_we;
    assign AddrW_o = r_addrW;
    assign DataW_o = r_dataW;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Images are streamed with random
// valid gaps; observed memory writes and final status are compared with a
// reference built from the image format (count header, little-endian words).
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              WE_o;
    logic [ADDR_W-1:0] AddrW_o;
    logic [DATA_W-1:0] DataW_o;
    logic              cpu_rst_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t seenWr[$];

    imem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .WE_o         (WE_o),
        .AddrW_o      (AddrW_o),
        .DataW_o      (DataW_o),
        .cpu_rst_o    (cpu_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Record every memory write away from the active edge
    always @(negedge clk_i) begin
        if (WE_o === 1'b1) seenWr.push_back({AddrW_o, DataW_o});
    end

    // Hard stop in case the loader wedges somewhere unexpected
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        seenWr.delete();
    endtask

    // Offer one byte after a random idle gap and hold it until accepted
    task automatic sendByte(input logic [7:0] b, input int gapMax);
        int  g;
        logic rdy;
        g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        repeat (g) begin
            byte_valid_i = 1'b0;
            byte_i       = 8'($urandom);
            @(posedge clk_i); #1;
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_i);
            rdy = byte_ready_o;
            @(posedge clk_i); #1;
            if (rdy) begin
                byte_valid_i = 1'b0;
                return;
            end
        end
        byte_valid_i = 1'b0;
        checkOutput("byteAcceptTimeout", 64'd0, 64'd1);
    endtask

    // Start a load, stream the image, and wait for a terminal status
    task automatic applyStimulus(input logic [7:0] im[$], input int gapMax);
        logic ok;
        pulseStart();
        foreach (im[i]) sendByte(im[i], gapMax);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_i);
            if (done_o || err_o) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("loadTimeout", 64'(ok), 64'd1);
    endtask

    // Reference: the header gives N; N>DEPTH aborts with no writes, otherwise
    // word k is bytes 2+4k..2+4k+3 little-endian at index k mod DEPTH.
    task automatic checkLoad(input string tag, input logic [7:0] im[$], input bit chkBad);
        int  n;
        int  nW;
        int  mism;
        bit  expErr;
        logic [DATA_W-1:0] w;
        n      = int'({im[1], im[0]});
        expErr = (n > DEPTH) || chkBad;
        nW     = (n > DEPTH) ? 0 : n;
        checkOutput({tag, ".nWrites"}, 64'(seenWr.size()), 64'(nW));
        mism = 0;
        for (int k = 0; k < nW && k < seenWr.size(); k++) begin
            w = {im[2+4*k+3], im[2+4*k+2], im[2+4*k+1], im[2+4*k]};
            if (nW <= 16) begin
                checkOutput($sformatf("%s.addr%0d", tag, k), 64'(seenWr[k].addr), 64'(k % DEPTH));
                checkOutput($sformatf("%s.data%0d", tag, k), 64'(seenWr[k].data), 64'(w));
            end else if (seenWr[k].addr != ADDR_W'(k % DEPTH) || seenWr[k].data != w) begin
                mism++;
            end
        end
        if (nW > 16) checkOutput({tag, ".wordMismatches"}, 64'(mism), 64'd0);
        checkOutput({tag, ".done"},   64'(done_o),    64'(!expErr));
        checkOutput({tag, ".err"},    64'(err_o),     64'(expErr));
        checkOutput({tag, ".cpuRst"}, 64'(cpu_rst_o), 64'(expErr));
        checkOutput({tag, ".busy"},   64'(busy_o),    64'd0);
    endtask

    // Build an image of n words of random data
    task automatic makeImage(input int n, output logic [7:0] im[$]);
        im.delete();
        im.push_back(8'(n));
        im.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) im.push_back(8'($urandom));
    endtask

    // Stream an image (plus the trailing sum byte when the option is built
    // in) and compare the result with the reference
    task automatic runImage(input string tag, input logic [7:0] im[$], input int gapMax, input bit chkBad);
        logic [7:0] tx[$];
        int         n;
        logic [7:0] sum;
        bit         bad;
        tx  = im;
        bad = 1'b0;
        n   = int'({im[1], im[0]});
`ifdef IMEM_LOADER_CHKSUM_EN
        if (n <= DEPTH) begin
            sum = 8'h00;
            for (int i = 2; i < im.size(); i++) sum = sum + im[i];
            tx.push_back(chkBad ? sum + 8'h01 : sum);
            bad = chkBad;
        end
`else
        sum = 8'h00;
        if (chkBad && sum != 8'h00) bad = 1'b1;
`endif
        applyStimulus(tx, gapMax);
        checkLoad(tag, im, bad);
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] part[$];

        rst_i        = 1'b1;
        start_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;

        // Reset values
        checkOutput("rst.ready",  64'(byte_ready_o), 64'd0);
        checkOutput("rst.we",     64'(WE_o),         64'd0);
        checkOutput("rst.addr",   64'(AddrW_o),      64'd0);
        checkOutput("rst.data",   64'(DataW_o),      64'd0);
        checkOutput("rst.busy",   64'(busy_o),       64'd0);
        checkOutput("rst.done",   64'(done_o),       64'd0);
        checkOutput("rst.err",    64'(err_o),        64'd0);
        checkOutput("rst.cpuRst", 64'(cpu_rst_o),    64'd1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("idle.ready", 64'(byte_ready_o), 64'd0);

        // Two-word image, back-to-back bytes
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        runImage("basic", img, 0, 1'b0);

        // Same image with random valid gaps
        runImage("gaps", img, 3, 1'b0);

        // Empty image
        img = '{8'h00, 8'h00};
        runImage("empty", img, 1, 1'b0);

        // One word too many for the memory, followed by bytes that get drained
        img = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        runImage("tooBig", img, 2, 1'b0);
        checkOutput("tooBig.readyInErr", 64'(byte_ready_o), 64'd1);

        // Recovery from ERR with a valid image
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        runImage("afterErr", img, 1, 1'b0);

        // Reset after half of word 0
        pulseStart();
        checkOutput("mid.busy",   64'(busy_o),    64'd1);
        checkOutput("mid.cpuRst", 64'(cpu_rst_o), 64'd1);
        part = '{8'h02, 8'h00, 8'h13, 8'h00};
        foreach (part[i]) sendByte(part[i], 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checkOutput("mid.cpuRstAfter", 64'(cpu_rst_o),     64'd1);
        checkOutput("mid.readyAfter",  64'(byte_ready_o),  64'd0);
        checkOutput("mid.busyAfter",   64'(busy_o),        64'd0);
        checkOutput("mid.noWrites",    64'(seenWr.size()), 64'd0);
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        runImage("fresh", img, 2, 1'b0);

        // Random small images
        for (int r = 0; r < 6; r++) begin
            makeImage(int'($urandom_range(12, 1)), img);
            runImage($sformatf("rand%0d", r), img, int'($urandom_range(3, 0)), 1'b0);
        end

        // Full memory image; last write lands on the top index
        makeImage(DEPTH, img);
        runImage("full", img, 0, 1'b0);
        if (seenWr.size() > 0) begin
            checkOutput("full.lastAddr", 64'(seenWr[$].addr), 64'(DEPTH - 1));
        end else begin
            checkOutput("full.lastAddr", 64'd0, 64'(DEPTH - 1));
        end

`ifdef IMEM_LOADER_CHKSUM_EN
        // Wrong trailing sum aborts the load
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        runImage("badSum", img, 1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
